// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among NUM_REQ byte producers.
// Optional packet lock when UART_ARB_LOCK_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RELEASE,
    ACK
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               lock_q, lock_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [1:0]         sync_q;
  logic               done_s;

  logic [NUM_REQ-1:0] elig;
  logic               hit;
  logic [IW-1:0]      pick;
  logic [NUM_REQ-1:0] pick_oh;
  logic [7:0]         sel_data;
  logic               sel_last;

  assign done_s   = sync_q[1];
  assign req_ack  = ack_q;
  assign grant    = grant_q;
  assign tx_data  = data_q;
  assign tx_valid = valid_q;
  assign busy     = (state_q != IDLE);

  // tx_done comes from the baud domain: two-flop synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], tx_done};
    end
  end

  // Round-robin pick: indices above the pointer first, then wrap to 0
  always_comb begin
    elig = lock_q ? (req & grant_q) : req;
    hit  = 1'b0;
    pick = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!hit && elig[j] && (IW'(j) > ptr_q)) begin
        hit  = 1'b1;
        pick = IW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!hit && elig[j] && (IW'(j) <= ptr_q)) begin
        hit  = 1'b1;
        pick = IW'(j);
      end
    end
  end

  // Mux the picked requester's byte, last flag and one-hot grant
  always_comb begin
    sel_data = 8'h00;
    sel_last = 1'b0;
    pick_oh  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick == IW'(j)) begin
        sel_data   = req_data[8*j +: 8];
        sel_last   = req_last[j];
        pick_oh[j] = 1'b1;
      end
    end
  end

  // Next-state and output decode for the grant/handshake FSM
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          grant_d = pick_oh;
          gidx_d  = pick;
          data_d  = sel_data;
          valid_d = 1'b1;
          last_d  = sel_last;
          state_d = SEND;
        end
      end
      SEND: begin
        if (done_s) begin
          valid_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!done_s) begin
          ack_d   = grant_q;
          state_d = ACK;
        end
      end
      ACK: begin
        ptr_d   = gidx_q;
        grant_d = '0;
        lock_d  = 1'b0;
        state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
        if (!last_q) begin
          lock_d  = 1'b1;
          grant_d = grant_q;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        lock_d  = 1'b0;
      end
    endcase
  end

`ifndef UART_ARB_LOCK_EN
  logic unused_last;
  assign unused_last = last_q;
`endif

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      lock_q  <= 1'b0;
      ptr_q   <= PTR_RST;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter.
// A small uart_tx stand-in drives tx_done.
module tb_uart_tx_arbiter;

  localparam int DLY = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .grant    (grant),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_done  (tx_done)
  );

  // transmitter stand-in: done rises DLY clk after valid, falls 2 clk after valid drops
  int tcnt;
  always @(posedge clk) begin
    if (reset) begin
      tx_done <= 1'b0;
      tcnt    <= 0;
    end else if (!tx_done) begin
      if (tx_valid) begin
        if (tcnt == DLY - 1) begin
          tx_done <= 1'b1;
          tcnt    <= 0;
        end else begin
          tcnt <= tcnt + 1;
        end
      end else begin
        tcnt <= 0;
      end
    end else if (!tx_valid) begin
      if (tcnt == 1) begin
        tx_done <= 1'b0;
        tcnt    <= 0;
      end else begin
        tcnt <= tcnt + 1;
      end
    end
  end

  function automatic int oh2i(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  int       g_q[$];
  int       d_q[$];
  int       cyc = 0;
  int       n_ack = 0;
  int       t_dr, t_vf, t_df, t_ack;
  logic     pv = 0, pd = 0;
  logic [3:0] pa = 0;

  // log every new byte handed to the transmitter and handshake edge times
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_valid && !pv) begin
      g_q.push_back(oh2i(grant));
      d_q.push_back(int'(tx_data));
    end
    if (tx_done && !pd) t_dr = cyc;
    if (!tx_valid && pv) t_vf = cyc;
    if (!tx_done && pd) t_df = cyc;
    if (req_ack != 0 && pa == 0) begin
      t_ack = cyc;
      n_ack = n_ack + 1;
    end
    pv = tx_valid;
    pd = tx_done;
    pa = req_ack;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (req_ack != 0) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (tx_valid) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    req      = '0;
    req_last = '0;
    req_data = '0;
    tick();
    tick();
    reset = 1'b0;
    g_q.delete();
    d_q.delete();
    n_ack = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = 4'hF;
    req_data = 32'hFFFF_FFFF;
    tick();
    tick();
    tests++;
    if (req_ack !== 4'b0) begin
      fails++;
      $display("FAIL reset_ack: got %b expected 0000", req_ack);
    end
    tests++;
    if (grant !== 4'b0) begin
      fails++;
      $display("FAIL reset_grant: got %b expected 0000", grant);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests++;
    if (tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %h expected 00", tx_data);
    end
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b expected 0", tx_valid);
    end
    do_reset();
  endtask

  task automatic test_single;
    bit ok;
    do_reset();
    req      = 4'b0010;
    req_data = 32'h0000_5500;
    wait_ack(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL single_timeout: got no ack expected ack");
    end
    tests++;
    if (req_ack !== 4'b0010) begin
      fails++;
      $display("FAIL single_ack: got %b expected 0010", req_ack);
    end
    req = 4'b0;
    tick();
    tests++;
    if (req_ack !== 4'b0) begin
      fails++;
      $display("FAIL single_ack_width: got %b expected 0000", req_ack);
    end
    tests++;
    if (g_q.size() != 1) begin
      fails++;
      $display("FAIL single_count: got %0d expected 1", g_q.size());
    end else begin
      tests++;
      if (d_q[0] != 'h55 || g_q[0] != 1) begin
        fails++;
        $display("FAIL single_byte: got %h/%0d expected 55/1", d_q[0], g_q[0]);
      end
    end
    tests++;
    if (t_vf - t_dr != 3) begin
      fails++;
      $display("FAIL done_path: got %0d expected 3", t_vf - t_dr);
    end
    tests++;
    if (t_ack - t_df != 3) begin
      fails++;
      $display("FAIL ack_path: got %0d expected 3", t_ack - t_df);
    end
    tick();
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_contention;
    bit ok;
    int eg[6];
    int ed[6];
    eg = '{0, 1, 3, 0, 1, 3};
    ed = '{'hA0, 'hA1, 'hA3, 'hA0, 'hA1, 'hA3};
    do_reset();
    req      = 4'b1011;
    req_data = 32'hA3EE_A1A0;
    for (int k = 0; k < 6; k++) begin
      wait_ack(ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL cont_timeout: got no ack %0d expected ack", k);
        break;
      end
      if (k == 5) req = 4'b0;
    end
    tick();
    tests++;
    if (g_q.size() != 6) begin
      fails++;
      $display("FAIL cont_count: got %0d expected 6", g_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (g_q[k] != eg[k] || d_q[k] != ed[k]) begin
          fails++;
          $display("FAIL cont_order[%0d]: got %0d/%h expected %0d/%h",
                   k, g_q[k], d_q[k], eg[k], ed[k]);
        end
      end
    end
  endtask

  task automatic test_late;
    bit ok;
    do_reset();
    req      = 4'b0001;
    req_data = 32'h0000_0010;
    wait_valid(ok);
    tick();
    tick();
    req      = 4'b0101;
    req_data = 32'h0012_0010;
    tick();
    tests++;
    if (tx_data !== 8'h10 || grant !== 4'b0001) begin
      fails++;
      $display("FAIL late_inflight: got %h/%b expected 10/0001", tx_data, grant);
    end
    wait_ack(ok);
    tests++;
    if (req_ack !== 4'b0001) begin
      fails++;
      $display("FAIL late_ack0: got %b expected 0001", req_ack);
    end
    req_data[7:0] = 8'h11;
    wait_ack(ok);
    tests++;
    if (req_ack !== 4'b0100) begin
      fails++;
      $display("FAIL late_ack2: got %b expected 0100", req_ack);
    end
    req = 4'b0001;
    wait_ack(ok);
    req = 4'b0;
    tick();
    tests++;
    if (g_q.size() != 3) begin
      fails++;
      $display("FAIL late_count: got %0d expected 3", g_q.size());
    end else begin
      tests++;
      if (g_q[1] != 2 || d_q[1] != 'h12 || g_q[2] != 0 || d_q[2] != 'h11) begin
        fails++;
        $display("FAIL late_order: got %0d/%h %0d/%h expected 2/12 0/11",
                 g_q[1], d_q[1], g_q[2], d_q[2]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset();
    req      = 4'b0001;
    req_data = 32'h9300_0033;
    wait_valid(ok);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    tests++;
    if (tx_valid !== 1'b0 || grant !== 4'b0 || req_ack !== 4'b0) begin
      fails++;
      $display("FAIL rmid_state: got %b/%b/%b expected 0/0000/0000",
               tx_valid, grant, req_ack);
    end
    req = 4'b1001;
    tick();
    reset = 1'b0;
    wait_valid(ok);
    tests++;
    if (!ok || grant !== 4'b0001 || tx_data !== 8'h33) begin
      fails++;
      $display("FAIL rmid_regrant: got %b/%h expected 0001/33", grant, tx_data);
    end
    tests++;
    if (n_ack != 0) begin
      fails++;
      $display("FAIL rmid_noack: got %0d expected 0", n_ack);
    end
  endtask

  task automatic test_early_drop;
    bit ok;
    do_reset();
    req      = 4'b1000;
    req_data = 32'h7700_0000;
    wait_valid(ok);
    tick();
    req = 4'b0;
    wait_ack(ok);
    tests++;
    if (!ok || req_ack !== 4'b1000) begin
      fails++;
      $display("FAIL drop_ack: got %b expected 1000", req_ack);
    end
    tick();
    tests++;
    if (d_q.size() != 1 || d_q[0] != 'h77) begin
      fails++;
      $display("FAIL drop_byte: got %0d bytes expected one 77", d_q.size());
    end
  endtask

  task automatic test_lock;
    bit ok;
    int b;
    int eg[4];
    int ed[4];
`ifdef UART_ARB_LOCK_EN
    eg = '{0, 0, 0, 1};
    ed = '{'hC0, 'hC1, 'hC2, 'hD0};
`else
    eg = '{0, 1, 0, 1};
    ed = '{'hC0, 'hD0, 'hC1, 'hD0};
`endif
    do_reset();
    b        = 0;
    req      = 4'b0011;
    req_data = 32'h0000_D0C0;
    req_last = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wait_ack(ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL lock_timeout: got no ack %0d expected ack", k);
        break;
      end
      if (req_ack[0]) begin
        b++;
        if (b == 3) begin
          req[0] = 1'b0;
        end else begin
          req_data[7:0] = 8'(8'hC0 + b);
          req_last[0]   = (b == 2);
        end
      end
      if (k == 3) req = 4'b0;
    end
    tick();
    tests++;
    if (g_q.size() != 4) begin
      fails++;
      $display("FAIL lock_count: got %0d expected 4", g_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (g_q[k] != eg[k] || d_q[k] != ed[k]) begin
          fails++;
          $display("FAIL lock_order[%0d]: got %0d/%h expected %0d/%h",
                   k, g_q[k], d_q[k], eg[k], ed[k]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_last = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_late();
    test_reset_mid();
    test_early_drop();
    test_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
